jtag_axi_txn_ctrl: RTL and testbench

//  Request-side controller upstream of the AXI master interface. Takes one decoded

---
 rtl/jtag_axi_pkg.sv | 59 +++++
 rtl/jtag_axi_txn_ctrl.sv | 138 +++++++++++++
 tb/tb_jtag_axi_txn_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_axi_pkg.sv
// Shared types for the JTAG-to-AXI bridge: AXI field types, FIFO entry layouts,
// transaction status codes and the request-controller FSM states.
package jtag_axi_pkg;

  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 32;

  typedef logic [AxiAddrWidth-1:0]   axi_addr_t;
  typedef logic [AxiDataWidth-1:0]   axi_data_t;
  typedef logic [AxiDataWidth/8-1:0] axi_wr_strb_t;
  typedef logic [2:0]                axi_size_t;

  typedef enum logic [1:0] {
    AXI_OKAY   = 2'd0,
    AXI_EXOKAY = 2'd1,
    AXI_SLVERR = 2'd2,
    AXI_DECERR = 2'd3
  } axi_resp_t;

  typedef enum logic {
    AXI_TXN_READ  = 1'b0,
    AXI_TXN_WRITE = 1'b1
  } axi_txn_type_t;

  typedef struct packed {
    axi_addr_t     addr;
    axi_size_t     size;
    axi_txn_type_t txn_type;
  } s_axi_afifo_to_axi_t;

  typedef struct packed {
    axi_data_t data_rd;
    axi_resp_t status;
  } s_axi_jtag_status_t;

  // Low codes mirror the AXI response so a response maps across by zero-extension.
  typedef enum logic [2:0] {
    JTAG_AXI_OKAY    = 3'd0,
    JTAG_AXI_EXOKAY  = 3'd1,
    JTAG_AXI_SLVERR  = 3'd2,
    JTAG_AXI_DECERR  = 3'd3,
    JTAG_AXI_IDLE    = 3'd4,
    JTAG_AXI_RUNNING = 3'd5,
    JTAG_AXI_TIMEOUT = 3'd6
  } jtag_axi_txn_st_t;

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitResp,
    StDone,
    StTimeout
  } jtag_txn_ctrl_st_t;

  function automatic jtag_axi_txn_st_t resp_to_st(axi_resp_t resp);
    return jtag_axi_txn_st_t'({1'b0, resp});
  endfunction

endpackage

// File: rtl/jtag_axi_txn_ctrl.sv
// Request-side controller: issues one JTAG-decoded AXI transaction into the async FIFOs,
// collects its response, enforces a timeout and drops responses of timed-out transactions.
module jtag_axi_txn_ctrl
  import jtag_axi_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned MAX_STALE      = 4
) (
  input  logic                clk,
  input  logic                ares,
  input  logic                update_i,
  input  logic                txn_start_i,
  input  logic                txn_write_i,
  input  axi_addr_t           txn_addr_i,
  input  axi_size_t           txn_size_i,
  input  axi_data_t           txn_data_i,
  input  axi_wr_strb_t        txn_wstrb_i,
  input  logic                afifo_txn_full_i,
  output logic                afifo_txn_wr_o,
  output s_axi_afifo_to_axi_t afifo_txn_o,
  input  logic                afifo_wd_full_i,
  output logic                afifo_wd_wr_o,
  output axi_data_t           afifo_wdata_o,
  output axi_wr_strb_t        afifo_wstrb_o,
  input  logic                afifo_rsp_empty_i,
  input  s_axi_jtag_status_t  afifo_rsp_i,
  output logic                afifo_rsp_rd_o,
  output jtag_axi_txn_st_t    status_o,
  output axi_data_t           rdata_o,
  output logic                busy_o,
  output logic                timeout_o,
  output logic                ovr_o
);

  localparam int unsigned TmoW   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int unsigned StaleW = (MAX_STALE > 0) ? $clog2(MAX_STALE + 1) : 1;
  localparam logic [TmoW-1:0]   TmoMax   = TmoW'(TIMEOUT_CYCLES);
  localparam logic [TmoW-1:0]   TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [StaleW-1:0] StaleMax = StaleW'(MAX_STALE);

  jtag_txn_ctrl_st_t state_q;
  logic              write_q;
  axi_addr_t         addr_q;
  axi_size_t         size_q;
  axi_data_t         data_q;
  axi_wr_strb_t      strb_q;
  logic [TmoW-1:0]   tmo_q;
  logic [StaleW-1:0] stale_q;
  jtag_axi_txn_st_t  status_q;
  axi_data_t         rdata_q;
  logic              ovr_q;

  logic in_rest, start, accept, push, pop, discard, tmo_hit;

  always_comb begin
    in_rest = state_q inside {StIdle, StDone, StTimeout};
    start   = update_i & txn_start_i;
    accept  = start & in_rest & (stale_q < StaleMax);
    // A write needs room in both FIFOs so address and data are pushed atomically.
    push    = (state_q == StIssue) & ~afifo_txn_full_i & (~write_q | ~afifo_wd_full_i);
    pop     = ~afifo_rsp_empty_i & ((state_q == StWaitResp) | (in_rest & (stale_q != '0)));
    discard = pop & (stale_q != '0);
    tmo_hit = (TIMEOUT_CYCLES != 0) && (state_q == StWaitResp) && !pop && (tmo_q == TmoLast);
  end

  always_ff @(posedge clk or posedge ares) begin
    if (ares) begin
      state_q  <= StIdle;
      write_q  <= 1'b0;
      addr_q   <= '0;
      size_q   <= '0;
      data_q   <= '0;
      strb_q   <= '0;
      tmo_q    <= '0;
      stale_q  <= '0;
      status_q <= JTAG_AXI_IDLE;
      rdata_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      if (discard) begin
        stale_q <= stale_q - StaleW'(1);
      end else if (tmo_hit && (stale_q != StaleMax)) begin
        stale_q <= stale_q + StaleW'(1);
      end
      if ((state_q == StWaitResp) && (tmo_q != TmoMax)) begin
        tmo_q <= tmo_q + TmoW'(1);
      end
      if (start && !accept) begin
        ovr_q <= 1'b1;
      end
      unique case (state_q)
        StIdle, StDone, StTimeout: begin
          if (accept) begin
            write_q  <= txn_write_i;
            addr_q   <= txn_addr_i;
            size_q   <= txn_size_i;
            data_q   <= txn_data_i;
            strb_q   <= txn_wstrb_i;
            ovr_q    <= 1'b0;
            rdata_q  <= '0;
            status_q <= JTAG_AXI_RUNNING;
            state_q  <= StIssue;
          end
        end
        StIssue: begin
          if (push) begin
            tmo_q   <= '0;
            state_q <= StWaitResp;
          end
        end
        StWaitResp: begin
          if (pop && !discard) begin
            status_q <= resp_to_st(afifo_rsp_i.status);
            rdata_q  <= write_q ? '0 : afifo_rsp_i.data_rd;
            state_q  <= StDone;
          end else if (tmo_hit) begin
            status_q <= JTAG_AXI_TIMEOUT;
            state_q  <= StTimeout;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign afifo_txn_wr_o = push;
  assign afifo_txn_o    = '{addr: addr_q, size: size_q, txn_type: axi_txn_type_t'(write_q)};
  assign afifo_wd_wr_o  = push & write_q;
  assign afifo_wdata_o  = data_q;
  assign afifo_wstrb_o  = strb_q;
  assign afifo_rsp_rd_o = pop;
  assign status_o       = status_q;
  assign rdata_o        = rdata_q;
  assign busy_o         = (state_q == StIssue) || (state_q == StWaitResp);
  assign timeout_o      = (state_q == StTimeout);
  assign ovr_o          = ovr_q;

endmodule

// File: tb/tb_jtag_axi_txn_ctrl.sv
// Scoreboard bench: two instances (MAX_STALE 4 and 1) share stimulus; only one is out of reset
// at a time and a negedge monitor checks FIFO pushes and transaction completions.
module tb_jtag_axi_txn_ctrl;
  import jtag_axi_pkg::*;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  size;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } push_t;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] rdata;
  } done_t;

  logic clk;
  logic ares_a, ares_b, sel_b;
  logic update, tstart, twrite;
  axi_addr_t addr;
  axi_size_t size;
  axi_data_t wdata;
  axi_wr_strb_t wstrb;
  logic txn_full, wd_full, rsp_empty;
  s_axi_jtag_status_t rsp;

  logic a_txn_wr, a_wd_wr, a_rsp_rd, a_busy, a_tmo, a_ovr;
  logic b_txn_wr, b_wd_wr, b_rsp_rd, b_busy, b_tmo, b_ovr;
  s_axi_afifo_to_axi_t a_txn, b_txn, m_txn;
  axi_data_t a_wdata, b_wdata, a_rdata, b_rdata, m_wdata, m_rdata;
  axi_wr_strb_t a_wstrb, b_wstrb, m_wstrb;
  jtag_axi_txn_st_t a_status, b_status, m_status;
  logic m_txn_wr, m_wd_wr, m_rsp_rd, m_busy, m_tmo, m_ovr;

  int checks, errors;
  push_t exp_push[$];
  done_t exp_done[$];
  push_t mon_e;
  done_t mon_d;
  logic mon_prev_busy;
  logic acc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  jtag_axi_txn_ctrl #(.TIMEOUT_CYCLES(8), .MAX_STALE(4)) dut_a (
    .clk(clk), .ares(ares_a), .update_i(update), .txn_start_i(tstart), .txn_write_i(twrite),
    .txn_addr_i(addr), .txn_size_i(size), .txn_data_i(wdata), .txn_wstrb_i(wstrb),
    .afifo_txn_full_i(txn_full), .afifo_txn_wr_o(a_txn_wr), .afifo_txn_o(a_txn),
    .afifo_wd_full_i(wd_full), .afifo_wd_wr_o(a_wd_wr), .afifo_wdata_o(a_wdata),
    .afifo_wstrb_o(a_wstrb), .afifo_rsp_empty_i(rsp_empty), .afifo_rsp_i(rsp),
    .afifo_rsp_rd_o(a_rsp_rd), .status_o(a_status), .rdata_o(a_rdata), .busy_o(a_busy),
    .timeout_o(a_tmo), .ovr_o(a_ovr)
  );

  jtag_axi_txn_ctrl #(.TIMEOUT_CYCLES(8), .MAX_STALE(1)) dut_b (
    .clk(clk), .ares(ares_b), .update_i(update), .txn_start_i(tstart), .txn_write_i(twrite),
    .txn_addr_i(addr), .txn_size_i(size), .txn_data_i(wdata), .txn_wstrb_i(wstrb),
    .afifo_txn_full_i(txn_full), .afifo_txn_wr_o(b_txn_wr), .afifo_txn_o(b_txn),
    .afifo_wd_full_i(wd_full), .afifo_wd_wr_o(b_wd_wr), .afifo_wdata_o(b_wdata),
    .afifo_wstrb_o(b_wstrb), .afifo_rsp_empty_i(rsp_empty), .afifo_rsp_i(rsp),
    .afifo_rsp_rd_o(b_rsp_rd), .status_o(b_status), .rdata_o(b_rdata), .busy_o(b_busy),
    .timeout_o(b_tmo), .ovr_o(b_ovr)
  );

  assign m_txn_wr = sel_b ? b_txn_wr : a_txn_wr;
  assign m_txn    = sel_b ? b_txn    : a_txn;
  assign m_wd_wr  = sel_b ? b_wd_wr  : a_wd_wr;
  assign m_wdata  = sel_b ? b_wdata  : a_wdata;
  assign m_wstrb  = sel_b ? b_wstrb  : a_wstrb;
  assign m_rsp_rd = sel_b ? b_rsp_rd : a_rsp_rd;
  assign m_status = sel_b ? b_status : a_status;
  assign m_rdata  = sel_b ? b_rdata  : a_rdata;
  assign m_busy   = sel_b ? b_busy   : a_busy;
  assign m_tmo    = sel_b ? b_tmo    : a_tmo;
  assign m_ovr    = sel_b ? b_ovr    : a_ovr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_txn(input logic wr, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] d, input logic [3:0] s, input logic accept);
    push_t p;
    update = 1'b1; tstart = 1'b1; twrite = wr; addr = a; size = sz; wdata = d; wstrb = s;
    if (accept) begin
      p.addr = a; p.size = sz; p.wr = wr; p.wdata = d; p.wstrb = s;
      exp_push.push_back(p);
    end
    step();
    update = 1'b0; tstart = 1'b0;
  endtask

  task automatic expect_done(input logic [2:0] st, input logic [31:0] rd);
    done_t d;
    d.st = st; d.rdata = rd;
    exp_done.push_back(d);
  endtask

  task automatic give_rsp(input logic [31:0] d, input axi_resp_t st);
    logic popped;
    popped = 1'b0;
    rsp.data_rd = d; rsp.status = st; rsp_empty = 1'b0;
    for (int i = 0; i < 40 && !popped; i++) begin
      @(negedge clk);
      popped = m_rsp_rd;
    end
    step();
    rsp_empty = 1'b1;
    check("rsp_popped", popped, 1);
  endtask

  task automatic wait_idle();
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < 40 && !idle; i++) begin
      @(negedge clk);
      idle = !m_busy;
    end
    check("idle_reached", idle, 1);
    step();
  endtask

  task automatic wait_tmo();
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      hit = m_tmo;
    end
    check("timeout_reached", hit, 1);
    step();
  endtask

  // Monitor: compares every push and every busy->idle completion against the queues.
  initial begin
    mon_prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (m_txn_wr) begin
        if (exp_push.size() == 0) begin
          check("unexpected_push", 1, 0);
        end else begin
          mon_e = exp_push.pop_front();
          check("push_addr", m_txn.addr, mon_e.addr);
          check("push_size", m_txn.size, mon_e.size);
          check("push_type", m_txn.txn_type, mon_e.wr);
          check("push_wd_wr", m_wd_wr, mon_e.wr);
          if (mon_e.wr) begin
            check("push_wdata", m_wdata, mon_e.wdata);
            check("push_wstrb", m_wstrb, mon_e.wstrb);
          end
        end
      end else if (m_wd_wr) begin
        check("lone_wd_push", m_wd_wr, 0);
      end
      if (mon_prev_busy && !m_busy) begin
        if (exp_done.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          mon_d = exp_done.pop_front();
          check("done_status", m_status, mon_d.st);
          check("done_rdata", m_rdata, mon_d.rdata);
        end
      end
      mon_prev_busy = m_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0; errors = 0;
    ares_a = 1'b1; ares_b = 1'b1; sel_b = 1'b0;
    update = 1'b0; tstart = 1'b0; twrite = 1'b0; addr = '0; size = '0; wdata = '0; wstrb = '0;
    txn_full = 1'b0; wd_full = 1'b0; rsp_empty = 1'b1; rsp = '0;
    repeat (3) step();
    ares_a = 1'b0;
    @(negedge clk);
    check("rst_status", m_status, JTAG_AXI_IDLE);
    check("rst_rdata", m_rdata, 0);
    check("rst_flags", {m_busy, m_tmo, m_ovr}, 0);
    check("rst_fifo_ctl", {m_txn_wr, m_wd_wr, m_rsp_rd}, 0);
    step();

    // 1: read with delayed OKAY response
    start_txn(1'b0, 32'h1000, 3'd2, 32'h0, 4'h0, 1'b1);
    repeat (5) step();
    expect_done(JTAG_AXI_OKAY, 32'hCAFEBABE);
    give_rsp(32'hCAFEBABE, AXI_OKAY);
    wait_idle();
    // status poll: update without start changes nothing
    update = 1'b1; step(); update = 1'b0;
    @(negedge clk);
    check("poll_status", m_status, JTAG_AXI_OKAY);
    check("poll_rdata", m_rdata, 32'hCAFEBABE);
    check("poll_busy", m_busy, 0);
    step();

    // 2: write held off by a full wr-data FIFO, then SLVERR
    wd_full = 1'b1;
    start_txn(1'b1, 32'h2000, 3'd2, 32'hDEADBEEF, 4'hF, 1'b1);
    acc = 1'b0;
    repeat (3) begin
      @(negedge clk);
      acc = acc | m_txn_wr | m_wd_wr;
    end
    check("wd_full_holdoff", acc, 0);
    step();
    wd_full = 1'b0;
    expect_done(JTAG_AXI_SLVERR, 32'h0);
    give_rsp(32'h12345678, AXI_SLVERR);
    wait_idle();

    // 3: timeout after 8 WAIT_RESP cycles, late response discarded
    start_txn(1'b0, 32'h3000, 3'd2, 32'h0, 4'h0, 1'b1);
    expect_done(JTAG_AXI_TIMEOUT, 32'h0);
    acc = 1'b0;
    repeat (9) begin
      @(negedge clk);
      acc = acc | m_tmo;
    end
    check("tmo_not_early", acc, 0);
    @(negedge clk);
    check("tmo_at_8", m_tmo, 1);
    check("tmo_status", m_status, JTAG_AXI_TIMEOUT);
    step();
    start_txn(1'b0, 32'h3004, 3'd2, 32'h0, 4'h0, 1'b1);
    give_rsp(32'hDEAD0000, AXI_OKAY);
    expect_done(JTAG_AXI_OKAY, 32'h55);
    give_rsp(32'h55, AXI_OKAY);
    wait_idle();

    // 4: start during WAIT_RESP is dropped and flags overrun
    start_txn(1'b0, 32'h4000, 3'd2, 32'h0, 4'h0, 1'b1);
    step();
    start_txn(1'b1, 32'h4444, 3'd2, 32'h1, 4'h1, 1'b0);
    @(negedge clk);
    check("ovr_set", m_ovr, 1);
    check("ovr_busy", m_busy, 1);
    step();
    expect_done(JTAG_AXI_OKAY, 32'h44);
    give_rsp(32'h44, AXI_OKAY);
    wait_idle();
    check("ovr_sticky", m_ovr, 1);
    start_txn(1'b0, 32'h4004, 3'd1, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    check("ovr_cleared", m_ovr, 0);
    step();
    expect_done(JTAG_AXI_EXOKAY, 32'h66);
    give_rsp(32'h66, AXI_EXOKAY);
    wait_idle();

    // 6: reset in WAIT_RESP with a stale entry outstanding
    start_txn(1'b0, 32'h6000, 3'd2, 32'h0, 4'h0, 1'b1);
    expect_done(JTAG_AXI_TIMEOUT, 32'h0);
    wait_tmo();
    start_txn(1'b0, 32'h6004, 3'd2, 32'h0, 4'h0, 1'b1);
    repeat (3) step();
    expect_done(JTAG_AXI_IDLE, 32'h0);
    ares_a = 1'b1;
    rsp.data_rd = 32'h77; rsp.status = AXI_OKAY; rsp_empty = 1'b0;
    @(negedge clk);
    check("ares_status", m_status, JTAG_AXI_IDLE);
    check("ares_ctl", {m_busy, m_txn_wr, m_wd_wr, m_rsp_rd}, 0);
    step();
    ares_a = 1'b0;
    @(negedge clk);
    check("ares_stale_clr", m_rsp_rd, 0);
    step();
    start_txn(1'b0, 32'h6008, 3'd2, 32'h0, 4'h0, 1'b1);
    expect_done(JTAG_AXI_OKAY, 32'h77);
    give_rsp(32'h77, AXI_OKAY);
    wait_idle();

    // 5: MAX_STALE=1 instance refuses a start until the late response drains
    ares_a = 1'b1; ares_b = 1'b0; sel_b = 1'b1;
    repeat (2) step();
    start_txn(1'b0, 32'h5000, 3'd2, 32'h0, 4'h0, 1'b1);
    expect_done(JTAG_AXI_TIMEOUT, 32'h0);
    wait_tmo();
    start_txn(1'b0, 32'h5004, 3'd2, 32'h0, 4'h0, 1'b0);
    @(negedge clk);
    check("stale_full_ovr", m_ovr, 1);
    check("stale_full_busy", m_busy, 0);
    step();
    give_rsp(32'hBAD, AXI_OKAY);
    @(negedge clk);
    check("drain_status", m_status, JTAG_AXI_TIMEOUT);
    step();
    start_txn(1'b0, 32'h5008, 3'd2, 32'h0, 4'h0, 1'b1);
    @(negedge clk);
    check("drained_ovr", m_ovr, 0);
    check("drained_busy", m_busy, 1);
    step();
    expect_done(JTAG_AXI_DECERR, 32'h88);
    give_rsp(32'h88, AXI_DECERR);
    wait_idle();

    repeat (2) step();
    check("push_q_empty", exp_push.size(), 0);
    check("done_q_empty", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
